ram_scan: RTL and testbench

RAM_SCAN -- requirements
Module: ram_scan

---
 rtl/ram_scan.sv | 141 ++++++++++++++
 tb/tb_ram_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan.sv
// ram_scan: small register-file RAM with a write FSM and an auto-scan read port.
//
// A rising edge on the wr_en switch level commits one write of data_in to
// mem[addr_in]. Otherwise the block either reads mem[addr_in] (manual mode) or
// steps a scan address through the array every SCAN_DIV cycles (scan mode).
// Read data is registered and tagged with the address it came from.
//
// Ports:
//   clk_2    - sole clock, rising edge
//   reset    - asynchronous, active-low reset
//   wr_en    - write request level (edge-detected internally)
//   scan_en  - 1: auto-scan addresses, 0: manual addressing via addr_in
//   addr_in  - manual read/write address
//   data_in  - write data
//   addr_out - address of the word currently on data_out
//   data_out - registered read data
//   valid    - data_out/addr_out hold a completed read (low in the write cycle)
//   wr_ack   - one-cycle pulse during the cycle a write is committed
module ram_scan #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SCAN_DIV   = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  scan_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    // Keep the prescaler at least one bit wide so SCAN_DIV = 1 still elaborates.
    localparam int unsigned PreW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StScan  = 2'd2
    } state_e;

    // Reset contents: the default 4-entry array holds 3, 6, 9, 12 (entry i
    // gets (i+1)*3); any other depth loads entry i with i*3. Both wrap to
    // DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH-1:0] init_word(input int unsigned idx);
        int unsigned v;
        v = (ADDR_WIDTH == 2) ? (idx + 1) * 3 : idx * 3;
        return DATA_WIDTH'(v);
    endfunction

    state_e                  state_q, state_d;
    logic                    wr_en_q;
    logic                    wr_rise;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [PreW-1:0]         pre_q;
    logic [DATA_WIDTH-1:0]   mem_q [Depth];
    logic [ADDR_WIDTH-1:0]   addr_out_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    valid_q;
    logic                    wr_ack_q;

    assign wr_rise = wr_en & ~wr_en_q;

    // A write edge wins from any state; otherwise every state (including the
    // one-cycle WRITE) simply follows scan_en.
    always_comb begin
        state_d = state_q;
        if (wr_rise) begin
            state_d = StWrite;
        end else if (scan_en) begin
            state_d = StScan;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_en_q    <= 1'b0;
            cnt_q      <= '0;
            pre_q      <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[ADDR_WIDTH'(i)] <= init_word(i);
            end
        end else begin
            state_q  <= state_d;
            wr_en_q  <= wr_en;
            valid_q  <= (state_d != StWrite);
            wr_ack_q <= (state_d == StWrite);
            unique case (state_q)
                StIdle: begin
                    // Holding the scan position at zero makes IDLE -> SCAN
                    // always restart from address 0.
                    cnt_q      <= '0;
                    pre_q      <= '0;
                    data_out_q <= mem_q[addr_in];
                    addr_out_q <= addr_in;
                end
                StWrite: begin
                    // Write-first: the read port shows the word being written.
                    // The scan counter stalls; the prescaler restarts so the
                    // resumed address gets a full dwell.
                    mem_q[addr_in] <= data_in;
                    data_out_q     <= data_in;
                    addr_out_q     <= addr_in;
                    pre_q          <= '0;
                end
                StScan: begin
                    data_out_q <= mem_q[cnt_q];
                    addr_out_q <= cnt_q;
                    if (pre_q == PreLast) begin
                        pre_q <= '0;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    pre_q <= '0;
                end
            endcase
        end
    end

    assign addr_out = addr_out_q;
    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_ram_scan.sv
// tb_ram_scan: self-checking bench for ram_scan at default parameters.
// A behavioural model predicts every output each cycle; directed checks pin
// hand-computed values for the key scenarios.
module tb_ram_scan;

    localparam int Depth = 4;
    localparam int Div   = 4;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       scan_en = 1'b0;
    logic [1:0] addr_in = 2'd2;
    logic [3:0] data_in = 4'd0;
    logic [1:0] addr_out;
    logic [3:0] data_out;
    logic       valid;
    logic       wr_ack;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] init_tab [4] = '{4'b0011, 4'b0110, 4'b1001, 4'b1100};

    ram_scan #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(4),
        .SCAN_DIV  (Div)
    ) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .wr_en   (wr_en),
        .scan_en (scan_en),
        .addr_in (addr_in),
        .data_in (data_in),
        .addr_out(addr_out),
        .data_out(data_out),
        .valid   (valid),
        .wr_ack  (wr_ack)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Scan address = (base + ticks / Div) mod Depth, where ticks counts scan
    // cycles since the last (re)start; a write rebases and restarts the dwell.
    logic [3:0] m_mem [4];
    logic       m_prev;
    int         m_mode;          // 0 idle, 1 write, 2 scan
    int         m_base, m_ticks, m_next;
    logic       m_rise;
    int         exp_data, exp_addr;
    logic       exp_valid, exp_ack;

    initial forever begin
        @(posedge clk_2 or negedge reset);
        if (!reset) begin
            for (int k = 0; k < Depth; k++) m_mem[k] = init_tab[k];
            m_prev = 1'b0; m_mode = 0; m_base = 0; m_ticks = 0;
            exp_data = 0; exp_addr = 0; exp_valid = 1'b0; exp_ack = 1'b0;
        end else begin
            m_rise = wr_en && !m_prev;
            m_prev = wr_en;
            case (m_mode)
                0: begin
                    exp_data = m_mem[addr_in]; exp_addr = addr_in;
                    m_base = 0; m_ticks = 0;
                end
                1: begin
                    m_mem[addr_in] = data_in;
                    exp_data = data_in; exp_addr = addr_in;
                    m_base = (m_base + m_ticks / Div) % Depth; m_ticks = 0;
                end
                default: begin
                    exp_addr = (m_base + m_ticks / Div) % Depth;
                    exp_data = m_mem[exp_addr];
                    m_ticks++;
                end
            endcase
            m_next = m_rise ? 1 : (scan_en ? 2 : 0);
            exp_valid = (m_next != 1);
            exp_ack   = (m_next == 1);
            m_mode    = m_next;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_2);
        if (!reset) begin
            check("cmp_rst_data", data_out, 0);
            check("cmp_rst_addr", addr_out, 0);
            check("cmp_rst_valid", valid, 0);
            check("cmp_rst_ack", wr_ack, 0);
        end else begin
            check("cmp_data", data_out, exp_data);
            check("cmp_addr", addr_out, exp_addr);
            check("cmp_valid", valid, exp_valid);
            check("cmp_ack", wr_ack, exp_ack);
        end
    end

    // ---------------- directed stimulus ----------------
    int acks;
    logic [1:0] j_addr [9] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [3:0] j_data [9] = '{4'd0, 4'd9, 4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0};
    logic       j_valid [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset state.
        @(negedge clk_2);
        check("rst_data_out", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_wr_ack", wr_ack, 0);
        @(negedge clk_2);
        reset = 1'b1;

        // Manual read of addr 2 right after release.
        @(negedge clk_2);
        check("man_read_data", data_out, 4'b1001);
        check("man_read_addr", addr_out, 2);
        check("man_read_valid", valid, 1);

        // Scan from IDLE: 0,1,2,3,0 each held Div cycles.
        scan_en = 1'b1;
        @(negedge clk_2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_2);
            check("scan_addr", addr_out, (i / 4) % 4);
            check("scan_data", data_out, init_tab[(i / 4) % 4]);
        end
        scan_en = 1'b0;
        addr_in = 2'd1;

        // Held write: one ack, write-first data, memory keeps the value.
        @(negedge clk_2);
        wr_en = 1'b1;
        data_in = 4'b1111;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_2);
            if (wr_ack) acks++;
            if (i == 1) check("write_first_data", data_out, 4'b1111);
        end
        wr_en = 1'b0;
        check("held_write_one_ack", acks, 1);
        @(negedge clk_2);
        check("mem1_kept", data_out, 4'b1111);
        check("mem1_kept_addr", addr_out, 1);

        // Write addr 3 = 0000 while the scan shows addr 2.
        scan_en = 1'b1;
        @(negedge clk_2);
        for (int k = 0; k < 10; k++) @(negedge clk_2);
        check("pre_write_scan_addr", addr_out, 2);
        wr_en = 1'b1;
        addr_in = 2'd3;
        data_in = 4'b0000;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk_2);
            if (j == 1) begin
                check("stall_ack", wr_ack, 1);
                wr_en = 1'b0;
            end
            check("stall_addr", addr_out, j_addr[j]);
            check("stall_data", data_out, j_data[j]);
            check("stall_valid", valid, j_valid[j]);
        end

        // Earlier write of 1111 to addr 0, then reset during the next WRITE.
        scan_en = 1'b0;
        addr_in = 2'd0;
        data_in = 4'b1111;
        wr_en = 1'b1;
        @(negedge clk_2);
        wr_en = 1'b0;
        @(negedge clk_2);
        @(negedge clk_2);
        check("w0_written", data_out, 4'b1111);
        data_in = 4'b0101;
        wr_en = 1'b1;
        acks = 0;
        @(posedge clk_2);
        #1 reset = 1'b0;
        @(negedge clk_2);
        if (wr_ack) acks++;
        @(negedge clk_2);
        if (wr_ack) acks++;
        wr_en = 1'b0;
        reset = 1'b1;
        @(negedge clk_2);
        if (wr_ack) acks++;
        check("abort_no_ack", acks, 0);
        check("abort_mem0_restored", data_out, 4'b0011);
        check("abort_addr", addr_out, 0);
        check("abort_valid", valid, 1);

        repeat (3) @(negedge clk_2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
